// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bundle: sync strobes plus the current pixel coordinate
// seen by downstream drawing logic.
interface vga_sync_gen_if;
    logic       hsync;
    logic       vsync;
    logic       vga_on;
    logic [9:0] Pixel_X;
    logic [8:0] Pixel_Y;
    logic       pixel_tick;
    logic       frame_start;

    modport master (
        output hsync, vsync, vga_on, Pixel_X, Pixel_Y, pixel_tick, frame_start
    );
    modport slave (
        input  hsync, vsync, vga_on, Pixel_X, Pixel_Y, pixel_tick, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: a clock-enable divider paces horizontal/vertical
// counters, and every output is a registered decode of the counter values.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           en,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             vga_on_q, vga_on_d;
    logic [9:0]       pixel_x_q, pixel_x_d;
    logic [8:0]       pixel_y_q, pixel_y_d;
    logic             pixel_tick_q, pixel_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             tick;
    logic             visible;

    // Next-state: divider, counters and decoded outputs of the pre-advance counters
    always_comb begin
        tick    = en && (div_q == DIV_MAX);
        visible = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        end

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        vga_on_d  = vga_on_q;
        pixel_x_d = pixel_x_q;
        pixel_y_d = pixel_y_q;
        if (tick) begin
            hsync_d   = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
            vsync_d   = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
            vga_on_d  = visible;
            pixel_x_d = visible ? h_cnt_q : '0;
            pixel_y_d = visible ? v_cnt_q[8:0] : '0;
        end

        pixel_tick_d  = tick;
        frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vga_on_q      <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vga_on_q      <= vga_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.vga_on      = vga_on_q;
    assign vga.Pixel_X     = pixel_x_q;
    assign vga.Pixel_Y     = pixel_y_q;
    assign vga.pixel_tick  = pixel_tick_q;
    assign vga.frame_start = frame_start_q;

endmodule
